// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter: grants one whole CYC-framed bus cycle at a time to one of N masters.
// Optional watchdog (define WB_ARBITER_TIMEOUT_EN) raises ERR to the owner when the slave never answers.

module wb_arbiter #(
    parameter int N_MASTERS      = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [N_MASTERS-1:0]                m_cyc,
    input  logic [N_MASTERS-1:0]                m_stb,
    input  logic [N_MASTERS-1:0]                m_we,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]     m_adr,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]     m_dat_w,
    input  logic [N_MASTERS*(DATA_WIDTH/8)-1:0] m_sel,
    output logic [DATA_WIDTH-1:0]               m_dat_r,
    output logic [N_MASTERS-1:0]                m_ack,
    output logic [N_MASTERS-1:0]                m_err,
    output logic                                s_cyc,
    output logic                                s_stb,
    output logic                                s_we,
    output logic [ADDR_WIDTH-1:0]               s_adr,
    output logic [DATA_WIDTH-1:0]               s_dat_w,
    output logic [DATA_WIDTH/8-1:0]             s_sel,
    input  logic [DATA_WIDTH-1:0]               s_dat_r,
    input  logic                                s_ack,
    input  logic                                s_err,
    output logic [N_MASTERS-1:0]                grant
);

    localparam int SEL_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    if (N_MASTERS < 2 || N_MASTERS > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("wb_arbiter: N_MASTERS must be 2..8 and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic                 busy;
    logic                 win_found;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     cand;
    logic                 timeout;

    logic [ADDR_WIDTH-1:0] adr_arr   [N_MASTERS];
    logic [DATA_WIDTH-1:0] dat_w_arr [N_MASTERS];
    logic [SEL_WIDTH-1:0]  sel_arr   [N_MASTERS];

    genvar gi;
    generate
        for (gi = 0; gi < N_MASTERS; gi++) begin : g_slice
            assign adr_arr[gi]   = m_adr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign dat_w_arr[gi] = m_dat_w[gi*DATA_WIDTH +: DATA_WIDTH];
            assign sel_arr[gi]   = m_sel[gi*SEL_WIDTH +: SEL_WIDTH];
        end
    endgenerate

    // last_q doubles as the owner index while BUSY, since it is loaded with the winner.
    assign busy = (state_q == BUSY);

    // First requester at or after last+1, wrapping modulo N_MASTERS.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        cand      = '0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            cand = IDX_W'((int'(last_q) + k) % N_MASTERS);
            if (!win_found && m_cyc[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(N_MASTERS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = BUSY;
                    grant_d = {{(N_MASTERS-1){1'b0}}, 1'b1} << win_idx;
                    last_d  = win_idx;
                end
            end
            BUSY: begin
                if (!m_cyc[last_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        m_ack   = '0;
        m_err   = '0;
        if (busy) begin
            s_cyc   = m_cyc[last_q];
            s_stb   = m_stb[last_q];
            s_we    = m_we[last_q];
            s_adr   = adr_arr[last_q];
            s_dat_w = dat_w_arr[last_q];
            s_sel   = sel_arr[last_q];
            m_ack   = grant_q & {N_MASTERS{s_ack}};
            m_err   = grant_q & {N_MASTERS{s_err | timeout}};
        end
    end

    assign m_dat_r = s_dat_r;
    assign grant   = grant_q;

`ifdef WB_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign timeout = busy && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && !s_ack && !s_err;

    // Counts consecutive unanswered strobe cycles; the firing cycle itself restarts the count.
    always_comb begin
        if (!busy || timeout || !s_stb || s_ack || s_err) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed test-plan scenarios plus randomized traffic against a
// behavioural owner/round-robin model, compared on every falling clock edge.

module tb_wb_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    m_cyc, m_stb, m_we;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat_w;
    logic [N*SW-1:0] m_sel;
    logic [DW-1:0]   m_dat_r;
    logic [N-1:0]    m_ack, m_err;
    logic            s_cyc, s_stb, s_we;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_dat_w;
    logic [SW-1:0]   s_sel;
    logic [DW-1:0]   s_dat_r;
    logic            s_ack, s_err;
    logic [N-1:0]    grant;

    int n_checks = 0;
    int n_errors = 0;

    wb_arbiter #(
        .N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_dat_w(m_dat_w), .m_sel(m_sel), .m_dat_r(m_dat_r),
        .m_ack(m_ack), .m_err(m_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_w(s_dat_w), .s_sel(s_sel), .s_dat_r(s_dat_r),
        .s_ack(s_ack), .s_err(s_err), .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    // Behavioural model: owner index (-1 = no owner), last winner, unanswered-strobe count.
    int mdl_owner = -1;
    int mdl_last  = N - 1;
    int mdl_cnt   = 0;
    int mdl_c;

    function automatic bit mdl_timeout();
`ifdef WB_ARBITER_TIMEOUT_EN
        return (mdl_owner >= 0) && (mdl_cnt == TO - 1) && !s_ack && !s_err;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_owner = -1;
            mdl_last  = N - 1;
            mdl_cnt   = 0;
        end else if (mdl_owner >= 0) begin
            if (mdl_timeout() || !m_stb[mdl_owner] || s_ack || s_err) mdl_cnt = 0;
            else mdl_cnt++;
            if (!m_cyc[mdl_owner]) mdl_owner = -1;
        end else begin
            mdl_cnt = 0;
            for (int k = 1; k <= N; k++) begin
                mdl_c = (mdl_last + k) % N;
                if (m_cyc[mdl_c]) begin
                    mdl_owner = mdl_c;
                    mdl_last  = mdl_c;
                    break;
                end
            end
        end
    end

    // Per-cycle scoreboard against the model.
    always @(negedge clk) begin
        logic [N-1:0]  eg, eack, eerr;
        logic          ecyc, estb, ewe;
        logic [AW-1:0] eadr;
        logic [DW-1:0] edat;
        logic [SW-1:0] esel;
        eg = '0; eack = '0; eerr = '0;
        ecyc = 1'b0; estb = 1'b0; ewe = 1'b0;
        eadr = '0; edat = '0; esel = '0;
        if (mdl_owner >= 0) begin
            eg[mdl_owner] = 1'b1;
            ecyc = m_cyc[mdl_owner];
            estb = m_stb[mdl_owner];
            ewe  = m_we[mdl_owner];
            eadr = m_adr[mdl_owner*AW +: AW];
            edat = m_dat_w[mdl_owner*DW +: DW];
            esel = m_sel[mdl_owner*SW +: SW];
            if (s_ack) eack = eg;
            if (s_err || mdl_timeout()) eerr = eg;
        end
        check("sb_grant", grant, eg);
        check("sb_s_ctrl", {s_cyc, s_stb, s_we}, {ecyc, estb, ewe});
        check("sb_s_adr", s_adr, eadr);
        check("sb_s_dat_w", s_dat_w, edat);
        check("sb_s_sel", s_sel, esel);
        check("sb_m_ack", m_ack, eack);
        check("sb_m_err", m_err, eerr);
        check("sb_m_dat_r", m_dat_r, s_dat_r);
    end

    task automatic quiet();
        m_cyc = '0; m_stb = '0; m_we = '0;
        s_ack = 1'b0; s_err = 1'b0;
        step();
        step();
    endtask

    logic [N-1:0] run_g [4];
    int           gaps  [3];
    int           runs, zero_cnt, bad;
    logic [N-1:0] prev_g, g, ackv;

    initial begin
        rst = 1'b1;
        m_cyc = 2'b11; m_stb = 2'b11; m_we = '0;
        m_adr = '0; m_dat_w = '0; m_sel = '0;
        s_dat_r = '0; s_ack = 1'b1; s_err = 1'b0;

        // Reset defaults with both masters requesting and a stray ACK.
        step(); step(); mid();
        check("rst_grant", grant, 2'b00);
        check("rst_s_cyc", s_cyc, 1'b0);
        check("rst_m_ack", m_ack, 2'b00);
        step();
        rst = 1'b0; s_ack = 1'b0;
        step(); mid();
        check("first_grant", grant, 2'b01);
        check("first_s_cyc", s_cyc, 1'b1);
        step();
        quiet();

        // Single read by master 1.
        m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b00;
        m_adr[AW +: AW] = 32'h0000_1000;
        step();
        s_ack = 1'b1; s_dat_r = 32'hDEAD_BEEF;
        mid();
        check("rd_s_adr", s_adr, 32'h0000_1000);
        check("rd_m_ack", m_ack, 2'b10);
        check("rd_m_dat_r", m_dat_r, 32'hDEAD_BEEF);
        check("rd_m_ack0", m_ack[0], 1'b0);
        step();
        quiet();

        // Simultaneous single-beat requesters: each drops CYC the cycle after its ACK.
        m_cyc = 2'b11; m_stb = 2'b11; s_ack = 1'b1;
        runs = 0; zero_cnt = 0; prev_g = '0;
        for (int c = 0; c < 30 && runs < 4; c++) begin
            mid();
            g = grant; ackv = m_ack;
            if (g != '0 && g != prev_g) begin
                run_g[runs] = g;
                if (runs > 0) gaps[runs-1] = zero_cnt;
                runs++;
                zero_cnt = 0;
            end else if (g == '0) begin
                zero_cnt++;
            end
            prev_g = g;
            step();
            m_cyc = ~ackv; m_stb = ~ackv;
        end
        check("alt_runs", runs, 4);
        check("alt_g0", run_g[0], 2'b01);
        check("alt_g1", run_g[1], 2'b10);
        check("alt_g2", run_g[2], 2'b01);
        check("alt_g3", run_g[3], 2'b10);
        for (int i = 0; i < 3; i++) check("alt_gap", gaps[i], 1);
        quiet();

        // Locked 4-beat burst by master 0 while master 1 waits.
        m_cyc = 2'b01; m_stb = 2'b01;
        step();
        m_cyc = 2'b11; m_stb = 2'b11; s_ack = 1'b1;
        for (int b = 0; b < 4; b++) begin
            mid();
            check("burst_ack", m_ack, 2'b01);
            step();
        end
        m_cyc = 2'b10; m_stb = 2'b10; s_ack = 1'b0;
        mid();
        check("burst_hold", grant, 2'b01);
        step(); mid();
        check("burst_idle_grant", grant, 2'b00);
        check("burst_idle_s_cyc", s_cyc, 1'b0);
        step(); mid();
        check("burst_next_grant", grant, 2'b10);
        step();
        quiet();

        // Hung slave under master 0.
        m_cyc = 2'b01; m_stb = 2'b01; s_ack = 1'b0; s_err = 1'b0;
        step();
        for (int k = 0; k < 12; k++) begin
            mid();
`ifdef WB_ARBITER_TIMEOUT_EN
            check("to_err0", m_err[0], (k == TO - 1) ? 1'b1 : 1'b0);
`else
            check("to_err0", m_err[0], 1'b0);
`endif
            step();
        end
`ifndef WB_ARBITER_TIMEOUT_EN
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            mid();
            if (m_err != '0) bad++;
            step();
        end
        check("to_none_1000", bad, 0);
`endif
        quiet();

        // Reset in the middle of master 1's strobed cycle.
        m_cyc = 2'b10; m_stb = 2'b10;
        step(); mid();
        check("rstmid_pre_s_cyc", s_cyc, 1'b1);
        rst = 1'b1;
        #1;
        check("rstmid_s_cyc", s_cyc, 1'b0);
        check("rstmid_grant", grant, 2'b00);
        m_cyc = 2'b11; m_stb = 2'b11;
        step();
        rst = 1'b0;
        step(); mid();
        check("rstmid_regrant", grant, 2'b01);
        step();
        quiet();

        // Randomized traffic; second half uses a slow slave to exercise the watchdog path.
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (m_cyc[i]) m_cyc[i] = ($urandom_range(3) != 0);
                else m_cyc[i] = ($urandom_range(2) == 0);
            end
            m_stb   = N'($urandom);
            m_we    = N'($urandom);
            m_adr   = {$urandom, $urandom};
            m_dat_w = {$urandom, $urandom};
            m_sel   = N*SW'($urandom);
            s_dat_r = $urandom;
            s_ack   = (c < 1000) ? ($urandom_range(1) == 0) : ($urandom_range(15) == 0);
            s_err   = ($urandom_range(15) == 0);
            rst     = ($urandom_range(299) == 0);
            step();
        end
        rst = 1'b0;
        quiet();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
